// File: rtl/dmux_rr_dispatcher.sv
// Round-robin dispatcher steering single items from one producer to one of eight channels.
// Optional per-channel eligibility mask enabled by defining DISPATCH_MASK_EN.
module dmux_rr_dispatcher #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [7:0]       ch_ready,
`ifdef DISPATCH_MASK_EN
  input  logic [7:0]       ch_mask,
`endif
  output logic [7:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [2:0]       ptr_r, ptr_next_s;
  logic [2:0]       sel_r, sel_next_s;
  logic [WIDTH-1:0] data_r, data_next_s;
  logic [7:0]       count_r, count_next_s;
  logic [7:0]       elig_s;
  logic             hit_s;
  logic [2:0]       pick_s;

  // First eligible channel at or after p, wrapping 7 -> 0; returns {hit, index}.
  function automatic logic [3:0] rr_search(input logic [7:0] elig, input logic [2:0] p);
    logic [3:0] found;
    logic [2:0] cand;
    found = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      cand = p + i[2:0];
      if (elig[cand]) begin
        found = {1'b1, cand};
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

`ifdef DISPATCH_MASK_EN
  assign elig_s = ch_ready & ch_mask;
`else
  assign elig_s = ch_ready;
`endif

  assign {hit_s, pick_s} = rr_search(elig_s, ptr_r);

  // Next-state and next-register computation.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    sel_next_s   = sel_r;
    data_next_s  = data_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          data_next_s = in_data;
          if (hit_s) begin
            sel_next_s   = pick_s;
            state_next_s = SEND;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (hit_s) begin
          sel_next_s   = pick_s;
          state_next_s = SEND;
        end else begin
          state_next_s = WAIT;
        end
      end
      SEND: begin
        // Completion looks only at the granted channel; the grant is sticky.
        if (ch_ready[sel_r]) begin
          ptr_next_s   = sel_r + 3'd1;
          count_next_s = count_r + 8'd1;
          state_next_s = IDLE;
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      sel_r   <= 3'd0;
      data_r  <= '0;
      count_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      sel_r   <= sel_next_s;
      data_r  <= data_next_s;
      count_r <= count_next_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == SEND) ? (8'h01 << sel_r) : 8'h00;
  assign out_data  = data_r;
  assign sel       = sel_r;
  assign count     = count_r;

endmodule

// File: tb/tb_dmux_rr_dispatcher.sv
// Randomized and directed bench for dmux_rr_dispatcher against a transaction-level model.
module tb_dmux_rr_dispatcher;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [7:0]   ch_ready;
  logic [7:0]   ch_mask;
  logic [7:0]   out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   sel;
  logic [7:0]   count;

  int total;
  int bad;

  // Model: granted channel (-1 = none), item waiting without grant, pointer, counter.
  int       m_grant;
  bit       m_pend;
  int       m_ptr;
  int       m_count;
  int       m_sel;
  logic [W-1:0] m_data;

  dmux_rr_dispatcher #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_ready  (ch_ready),
`ifdef DISPATCH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8] && m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_grant < 0 && !m_pend)});
    chk("out_valid", {24'd0, out_valid}, (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
    chk("sel", {29'd0, sel}, m_sel);
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("count", {24'd0, count}, m_count);
  endtask

  task automatic model_reset();
    m_grant = -1; m_pend = 1'b0; m_ptr = 0; m_count = 0; m_sel = 0; m_data = '0;
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare after the edge.
  task automatic step();
    logic [7:0] m;
    int c;
`ifdef DISPATCH_MASK_EN
    m = ch_mask;
`else
    m = 8'hFF;
`endif
    if (m_grant >= 0) begin
      if (ch_ready[m_grant]) begin
        m_ptr   = (m_grant + 1) % 8;
        m_count = (m_count + 1) % 256;
        m_grant = -1;
      end
    end else if (m_pend || in_valid) begin
      if (!m_pend) m_data = in_data;
      c = pick(ch_ready, m, m_ptr);
      if (c >= 0) begin
        m_grant = c; m_sel = c; m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", {24'd0, out_valid}, 32'h00);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {24'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [W-1:0] d, input logic [7:0] r);
    in_valid = 1'b1; in_data = d; ch_ready = r;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; ch_ready = 8'h00; ch_mask = 8'hFF;
    #2;
    do_reset();

    // First item: grant ch0 next cycle, completes the following edge.
    send(8'h01, 8'hFF);
    chk("first_grant", {24'd0, out_valid}, 32'h01);
    step();
    chk("first_count", {24'd0, count}, 32'd1);

    // Back-to-back items grant ch1..ch4 with in_ready alternating.
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + i[7:0], 8'hFF);
      chk("b2b_grant", {24'd0, out_valid}, 32'h02 << i);
      step();
    end
    chk("b2b_count", {24'd0, count}, 32'd5);

    // ptr is 5 now; one more with FF brings it to 6, then only ch5 ready must wrap.
    send(8'h33, 8'hFF);
    step();
    send(8'h44, 8'h20);
    chk("wrap_grant", {24'd0, out_valid}, 32'h20);
    chk("wrap_sel", {29'd0, sel}, 32'd5);
    step();
    send(8'h55, 8'hFF);
    chk("ptr_after_wrap", {29'd0, sel}, 32'd6);
    step();

    // No channel ready: hold in WAIT, then ch3 appears.
    send(8'h66, 8'h00);
    for (int i = 0; i < 5; i++) step();
    ch_ready = 8'h08;
    step();
    chk("wait_grant", {24'd0, out_valid}, 32'h08);
    step();

    // Sticky grant on ch2 while ch4 is ready.
    do_reset();
    send(8'h77, 8'h04);
    for (int i = 0; i < 3; i++) begin
      ch_ready = 8'h10;
      step();
      chk("sticky_valid", {24'd0, out_valid}, 32'h04);
      chk("sticky_data", {24'd0, out_data}, 32'h77);
    end
    ch_ready = 8'h04;
    step();

`ifdef DISPATCH_MASK_EN
    do_reset();
    ch_mask = 8'hFE;
    send(8'h88, 8'hFF);
    chk("mask_grant", {24'd0, out_valid}, 32'h02);
    step();
    ch_mask = 8'hFF;
`endif

    // Randomized traffic with sparse readiness.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      ch_ready = 8'($urandom) & 8'($urandom);
`ifdef DISPATCH_MASK_EN
      ch_mask  = 8'($urandom) | 8'($urandom);
`endif
      step();
    end

    // Asynchronous reset in the middle of a SEND.
    in_valid = 1'b0; ch_ready = 8'hFF;
    step();
    send(8'h99, 8'h01);
    ch_ready = 8'h00;
    step();
    chk("pre_rst_send", {24'd0, out_valid}, (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
    do_reset();
    send(8'hAA, 8'hFF);
    chk("post_rst_ptr", {29'd0, sel}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
